// File: rtl/ps2_move_decoder.sv
// PS/2 scancode stream to held arrow-key direction levels with opposing-key resolution and stuck-key timeout.
// Optional build macro PS2_MOVE_WASD_EN adds the non-extended W/S/A/D codes as direction sources.
module ps2_move_decoder #(
   parameter int TIMEOUT = 25000000,
   parameter int CNT_W   = 25
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] ps2_key_data,
   input  logic       ps2_key_pressed,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       key_event
);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   // held/dir bit order: [3]=up, [2]=down, [1]=left, [0]=right
   state_t           state_q, state_n;
   logic [3:0]       held_q, held_n;
   logic [3:0]       dir_q, dir_n;
   logic             vpri_q, vpri_n, hpri_q, hpri_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             is_make, is_brk, is_ext;
   logic             key_hit;
   logic [1:0]       key_idx;
   logic             make_hit;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_n = state_q;
      is_make = 1'b0;
      is_brk  = 1'b0;
      is_ext  = 1'b0;
      if (ps2_key_pressed) begin
         unique case (state_q)
            S_IDLE: begin
               if (ps2_key_data == 8'hE0)      state_n = S_EXT;
               else if (ps2_key_data == 8'hF0) state_n = S_BRK;
               else                            is_make = 1'b1;
            end
            S_EXT: begin
               if (ps2_key_data == 8'hF0) state_n = S_EXT_BRK;
               else begin
                  is_make = 1'b1;
                  is_ext  = 1'b1;
                  state_n = S_IDLE;
               end
            end
            S_BRK: begin
               is_brk  = 1'b1;
               state_n = S_IDLE;
            end
            S_EXT_BRK: begin
               is_brk  = 1'b1;
               is_ext  = 1'b1;
               state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_comb begin
      key_hit = 1'b0;
      key_idx = 2'd0;
      if (is_ext) begin
         unique case (ps2_key_data)
            8'h75: begin key_hit = 1'b1; key_idx = 2'd3; end
            8'h72: begin key_hit = 1'b1; key_idx = 2'd2; end
            8'h6B: begin key_hit = 1'b1; key_idx = 2'd1; end
            8'h74: begin key_hit = 1'b1; key_idx = 2'd0; end
            default: key_hit = 1'b0;
         endcase
      end else begin
`ifdef PS2_MOVE_WASD_EN
         unique case (ps2_key_data)
            8'h1D: begin key_hit = 1'b1; key_idx = 2'd3; end
            8'h1B: begin key_hit = 1'b1; key_idx = 2'd2; end
            8'h1C: begin key_hit = 1'b1; key_idx = 2'd1; end
            8'h23: begin key_hit = 1'b1; key_idx = 2'd0; end
            default: key_hit = 1'b0;
         endcase
`else
         key_hit = 1'b0;
`endif
      end
   end

   assign make_hit = is_make & key_hit;

   always_comb begin
      held_n = held_q;
      vpri_n = vpri_q;
      hpri_n = hpri_q;
      cnt_n  = cnt_q;
      if (make_hit) begin
         held_n[key_idx] = 1'b1;
         if (key_idx[1]) vpri_n = key_idx[0];
         else            hpri_n = key_idx[0];
      end else if (is_brk && key_hit) begin
         held_n[key_idx] = 1'b0;
      end

      // Strobe is applied first; a recognised make clears the counter and so suppresses expiry.
      if (make_hit || held_n == 4'b0000) begin
         cnt_n = '0;
      end else if (LIMIT != '0 && cnt_q == LIMIT - 1'b1) begin
         held_n = 4'b0000;
         cnt_n  = '0;
      end else begin
         cnt_n = cnt_q + 1'b1;
      end

      dir_n[3] = held_n[3] & (~held_n[2] |  vpri_n);
      dir_n[2] = held_n[2] & (~held_n[3] | ~vpri_n);
      dir_n[1] = held_n[1] & (~held_n[0] |  hpri_n);
      dir_n[0] = held_n[0] & (~held_n[1] | ~hpri_n);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         held_q    <= 4'b0000;
         dir_q     <= 4'b0000;
         vpri_q    <= 1'b0;
         hpri_q    <= 1'b0;
         cnt_q     <= '0;
         key_event <= 1'b0;
      end else begin
         state_q   <= state_n;
         held_q    <= held_n;
         dir_q     <= dir_n;
         vpri_q    <= vpri_n;
         hpri_q    <= hpri_n;
         cnt_q     <= cnt_n;
         key_event <= (dir_n != dir_q);
      end
   end

   assign up    = dir_q[3];
   assign down  = dir_q[2];
   assign left  = dir_q[1];
   assign right = dir_q[0];

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed self-checking bench for ps2_move_decoder with TIMEOUT=100; follows PS2_MOVE_WASD_EN when defined.
module tb_ps2_move_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] ps2_key_data = 8'h00;
   logic       ps2_key_pressed = 1'b0;
   logic       up, down, left, right, key_event;

   int checks   = 0;
   int failures = 0;
   int ev_count = 0;

   ps2_move_decoder #(.TIMEOUT(100), .CNT_W(8)) dut (
      .clock           (clock),
      .reset           (reset),
      .ps2_key_data    (ps2_key_data),
      .ps2_key_pressed (ps2_key_pressed),
      .up              (up),
      .down            (down),
      .left            (left),
      .right           (right),
      .key_event       (key_event)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One strobe; returns on the falling edge after the sampling edge, where outputs reflect it.
   task automatic send(input logic [7:0] b);
      ps2_key_data    = b;
      ps2_key_pressed = 1'b1;
      @(negedge clock);
      ps2_key_pressed = 1'b0;
      if (key_event) ev_count++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         if (key_event) ev_count++;
      end
   endtask

   function automatic logic [3:0] dirs();
      return {up, down, left, right};
   endfunction

   initial begin
      repeat (3) @(negedge clock);
      check("reset_dirs", 32'(dirs()), 32'h0);
      check("reset_event", 32'(key_event), 32'h0);
      reset = 1'b0;
      tick(2);

      // Arrow press and release
      ev_count = 0;
      send(8'hE0);
      check("up_prefix_no_change", 32'(dirs()), 32'h0);
      send(8'h75);
      check("up_press", 32'(dirs()), 32'h8);
      check("up_press_event", 32'(key_event), 32'h1);
      tick(1);
      check("event_one_cycle", 32'(key_event), 32'h0);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("up_release", 32'(dirs()), 32'h0);
      check("up_release_event", 32'(key_event), 32'h1);
      tick(1);
      check("press_release_events", 32'(ev_count), 32'd2);

      // Opposing vertical keys
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'h72);
      check("down_over_up", 32'(dirs()), 32'h4);
      check("down_over_up_event", 32'(key_event), 32'h1);
      send(8'hE0); send(8'hF0); send(8'h72);
      check("up_reexposed", 32'(dirs()), 32'h8);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("vert_all_released", 32'(dirs()), 32'h0);

      // Opposing horizontal keys
      send(8'hE0); send(8'h74);
      check("right_press", 32'(dirs()), 32'h1);
      send(8'hE0); send(8'h6B);
      check("left_over_right", 32'(dirs()), 32'h2);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("right_reexposed", 32'(dirs()), 32'h1);
      send(8'hE0); send(8'hF0); send(8'h74);
      check("horiz_all_released", 32'(dirs()), 32'h0);
      tick(2);

      // Typematic repeat keeps left alive, then timeout clears it
      ev_count = 0;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) tick(50);
         send(8'hE0); send(8'h6B);
         check("typematic_left", 32'(dirs()), 32'h2);
      end
      tick(99);
      check("left_before_timeout", 32'(dirs()), 32'h2);
      check("typematic_single_event", 32'(ev_count), 32'd1);
      @(negedge clock);
      check("left_timeout_cleared", 32'(dirs()), 32'h0);
      check("timeout_event", 32'(key_event), 32'h1);
      tick(2);

      // Reset mid-sequence returns the parser to IDLE
      send(8'hE0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midseq_reset_dirs", 32'(dirs()), 32'h0);
      send(8'h75);
      check("plain_75_ignored", 32'(dirs()), 32'h0);
      check("plain_75_no_event", 32'(key_event), 32'h0);
      send(8'hE0); send(8'h75);
      check("parser_recovered", 32'(dirs()), 32'h8);

      // Unknown extended code while a key is held
      send(8'hE0); send(8'h12);
      check("e0_12_held_no_change", 32'(dirs()), 32'h8);
      check("e0_12_no_event", 32'(key_event), 32'h0);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("up_release_2", 32'(dirs()), 32'h0);
      send(8'hE0); send(8'h12);
      check("e0_12_idle_no_change", 32'(dirs()), 32'h0);
      tick(1);

      // Plain W make/break
      send(8'h1D);
`ifdef PS2_MOVE_WASD_EN
      check("w_make", 32'(dirs()), 32'h8);
      check("w_make_event", 32'(key_event), 32'h1);
`else
      check("w_make_ignored", 32'(dirs()), 32'h0);
      check("w_make_no_event", 32'(key_event), 32'h0);
`endif
      send(8'hF0); send(8'h1D);
      check("w_break", 32'(dirs()), 32'h0);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
